// File: rtl/bitwise_logic_unit.sv
// ============================================================================
// Module   : bitwise_logic_unit
// Brief    : Two-stage pipelined AND/OR/XOR/ANDN unit with accumulate mode,
//            valid/ready handshakes and zero/all-ones/parity result flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitwise_logic_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity
);

    localparam logic [1:0] c_OP_AND  = 2'b00;
    localparam logic [1:0] c_OP_OR   = 2'b01;
    localparam logic [1:0] c_OP_XOR  = 2'b10;
    localparam logic [1:0] c_OP_ANDN = 2'b11;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_data;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_data;
    logic             r_s2_zero;
    logic             r_s2_ones;
    logic             r_s2_parity;
    logic [WIDTH-1:0] r_acc;

    logic             w_accept;
    logic             w_advance;
    logic             w_consume;
    logic [WIDTH-1:0] w_a_eff;
    logic [WIDTH-1:0] w_result;

    // Ready looks through to out_ready so a full pipe drains and refills
    // on the same edge without a bubble.
    assign in_ready  = !r_s1_valid || !r_s2_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_advance = r_s1_valid && (!r_s2_valid || out_ready);
    assign w_consume = r_s2_valid && out_ready;
    assign w_a_eff   = in_acc ? r_acc : in_a;

    always_comb begin
        w_result = '0;
        case (in_op)
            c_OP_AND:  w_result = w_a_eff & in_b;
            c_OP_OR:   w_result = w_a_eff | in_b;
            c_OP_XOR:  w_result = w_a_eff ^ in_b;
            c_OP_ANDN: w_result = w_a_eff & ~in_b;
            default:   w_result = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_acc      <= '0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_data  <= w_result;
                r_acc      <= w_result;
            end else if (w_advance) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // Flags are derived from S1 so the output side is purely registered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid  <= 1'b0;
            r_s2_data   <= '0;
            r_s2_zero   <= 1'b0;
            r_s2_ones   <= 1'b0;
            r_s2_parity <= 1'b0;
        end else begin
            if (w_advance) begin
                r_s2_valid  <= 1'b1;
                r_s2_data   <= r_s1_data;
                r_s2_zero   <= ~|r_s1_data;
                r_s2_ones   <= &r_s1_data;
                r_s2_parity <= ^r_s1_data;
            end else if (w_consume) begin
                r_s2_valid  <= 1'b0;
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_data   = r_s2_data;
    assign out_zero   = r_s2_zero;
    assign out_ones   = r_s2_ones;
    assign out_parity = r_s2_parity;

endmodule

`default_nettype wire
